// File: rtl/vram_pkg.sv
// vram_pkg: shared constants and types for the VRAM arbiter.
//   VGA_H_OFS / VGA_V_OFS : raw timing counts at the first visible pixel
//   H_ACTIVE / V_ACTIVE   : visible frame size in pixels
//   PIXEL_W / ADDR_W      : pixel width (bbbb_gggg_rrrr) and RAM address width
//   arb_state_e           : arbiter FSM states
package vram_pkg;

    localparam int unsigned VGA_H_OFS = 143;
    localparam int unsigned VGA_V_OFS = 35;
    localparam int unsigned H_ACTIVE  = 640;
    localparam int unsigned V_ACTIVE  = 480;
    localparam int unsigned PIXEL_W   = 12;
    localparam int unsigned ADDR_W    = 19;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } arb_state_e;

endpackage

// File: rtl/vram_addr_map.sv
// vram_addr_map: removes the timing offsets from a (row, col) pair and flags
// whether the result lies inside the visible frame.
//   row_i      : raw row count (10 bits)
//   col_i      : raw column count (10 bits)
//   addr_o     : {row_rel[8:0], col_rel[9:0]} pixel RAM address
//   in_range_o : 1 when col_rel < H_ACTIVE and row_rel < V_ACTIVE
module vram_addr_map
    import vram_pkg::*;
#(
    parameter int unsigned HOfs = 0,
    parameter int unsigned VOfs = 0
) (
    input  logic [9:0]        row_i,
    input  logic [9:0]        col_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              in_range_o
);

    logic [9:0] row_rel;
    logic [9:0] col_rel;

    // Wraparound makes counts below the offset look huge, so they fail the range check.
    assign row_rel    = row_i - 10'(VOfs);
    assign col_rel    = col_i - 10'(HOfs);
    assign addr_o     = {row_rel[8:0], col_rel};
    assign in_range_o = (row_rel < 10'(V_ACTIVE)) && (col_rel < 10'(H_ACTIVE));

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port pixel RAM between the display fetch
// and a CPU port. The display owns every cycle with vga_rdn low; the CPU is
// granted any other cycle and acknowledged one cycle later.
//   clk, rstn        : clock, synchronous active-low reset
//   vga_rdn/row/col  : display slot and raw timing counts
//   vga_data         : fetched pixel, two cycles after the slot
//   cpu_*            : request/ack CPU port, one access per two cycles max
//   ram_*            : pixel RAM port (read data has one cycle of latency)
//   stall_cnt        : CPU cycles blocked by display slots
// Optional feature macro: VRAM_ARB_STALLCNT_EN enables the stall counter;
// otherwise stall_cnt is tied to zero.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned STALL_W = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               vga_rdn,
    input  logic [9:0]         vga_row,
    input  logic [9:0]         vga_col,
    output logic [PIXEL_W-1:0] vga_data,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [PIXEL_W-1:0] cpu_wdata,
    output logic               cpu_ack,
    output logic [PIXEL_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [PIXEL_W-1:0] ram_wdata,
    input  logic [PIXEL_W-1:0] ram_rdata,
    output logic [STALL_W-1:0] stall_cnt
);

    arb_state_e         state_q;
    logic               ack_q;
    logic               rd_q;
    logic               zero_q;
    logic [PIXEL_W-1:0] rdata_q;
    logic [PIXEL_W-1:0] done_rdata;
    logic [ADDR_W-1:0]  addr_q;
    logic               slot_q;
    logic [PIXEL_W-1:0] vga_q;

    logic [ADDR_W-1:0]  disp_addr;
    logic [ADDR_W-1:0]  cpu_map_addr;
    logic               cpu_in_range;
    logic               unused_disp_in_range;
    logic               slot;
    logic               grant;

    vram_addr_map #(
        .HOfs (VGA_H_OFS),
        .VOfs (VGA_V_OFS)
    ) u_disp_map (
        .row_i      (vga_row),
        .col_i      (vga_col),
        .addr_o     (disp_addr),
        .in_range_o (unused_disp_in_range)
    );

    vram_addr_map #(
        .HOfs (0),
        .VOfs (0)
    ) u_cpu_map (
        .row_i      ({1'b0, cpu_addr[ADDR_W-1:10]}),
        .col_i      (cpu_addr[9:0]),
        .addr_o     (cpu_map_addr),
        .in_range_o (cpu_in_range)
    );

    assign slot  = ~vga_rdn;
    // No grant during reset so an aborted request can never touch the RAM.
    assign grant = rstn && (state_q != StDone) && cpu_req && vga_rdn;

    always_comb begin
        ram_addr  = addr_q;
        ram_we    = 1'b0;
        ram_wdata = cpu_wdata;
        if (slot) begin
            ram_addr = disp_addr;
        end else if (grant) begin
            ram_addr = cpu_map_addr;
            ram_we   = cpu_we & cpu_in_range;
        end
    end

    // ram_rdata in the DONE cycle belongs to the granted address.
    assign done_rdata = zero_q ? '0 : ram_rdata;
    assign cpu_rdata  = (ack_q && rd_q) ? done_rdata : rdata_q;
    assign cpu_ack    = ack_q & rstn;
    assign vga_data   = vga_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
            rd_q    <= 1'b0;
            zero_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                StIdle, StWait: begin
                    if (!cpu_req) begin
                        state_q <= StIdle;
                    end else if (vga_rdn) begin
                        state_q <= StDone;
                        ack_q   <= 1'b1;
                        rd_q    <= ~cpu_we;
                        zero_q  <= ~cpu_in_range;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    if (rd_q) begin
                        rdata_q <= done_rdata;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_q <= '0;
            slot_q <= 1'b0;
            vga_q  <= '0;
        end else begin
            addr_q <= ram_addr;
            slot_q <= slot;
            if (slot_q) begin
                vga_q <= ram_rdata;
            end
        end
    end

`ifdef VRAM_ARB_STALLCNT_EN
    logic               blocked;
    logic [STALL_W-1:0] stall_q;

    // A blocked cycle is one whose next state is WAIT.
    assign blocked = (state_q != StDone) && cpu_req && slot;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_q <= '0;
        end else if (blocked && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scenarios for vram_arbiter with a cycle-level
// reference model (pixel image + pending-ack/display pipelines) compared on
// every negative clock edge, plus literal expectations per scenario.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        vga_rdn;
    logic [9:0]  vga_row;
    logic [9:0]  vga_col;
    logic [11:0] vga_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [18:0] cpu_addr;
    logic [11:0] cpu_wdata;
    logic        cpu_ack;
    logic [11:0] cpu_rdata;
    logic [18:0] ram_addr;
    logic        ram_we;
    logic [11:0] ram_wdata;
    bit   [11:0] ram_rdata;
    logic [15:0] stall_cnt;

    vram_arbiter #(
        .STALL_W (16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .vga_rdn   (vga_rdn),
        .vga_row   (vga_row),
        .vga_col   (vga_col),
        .vga_data  (vga_data),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Pixel RAM; columns past the frame read back as junk (0xFFF).
    bit [11:0] mem [0:524287];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= (ram_addr[9:0] >= 10'd640) ? 12'hFFF : mem[ram_addr];
    end

    int n_chk  = 0;
    int n_fail = 0;
    int ack_cnt = 0;
    int we_cnt  = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model state.
    bit [11:0]   img [0:524287];
    bit          model_on = 1'b0;
    bit          m_ack_now, m_ack_read, m_s1_valid, m_last_valid;
    logic [11:0] m_ack_val, m_rdata, m_vga, m_s1_val;
    logic [15:0] m_stall;
    logic [18:0] m_last;

    function automatic void model_reset();
        m_ack_now    = 1'b0;
        m_ack_read   = 1'b0;
        m_s1_valid   = 1'b0;
        m_last_valid = 1'b0;
        m_rdata      = 12'h000;
        m_vga        = 12'h000;
        m_stall      = 16'd0;
    endfunction

    always @(negedge clk) begin
        logic [18:0] d_addr, e_addr;
        bit          slot, elig, inr, e_we, blocked;
        int          crow, ccol, r, c;
        r      = int'(vga_row) - 35;
        c      = int'(vga_col) - 143;
        d_addr = 19'(((r & 511) * 1024) + (c & 1023));
        crow   = int'(cpu_addr) / 1024;
        ccol   = int'(cpu_addr) % 1024;
        inr    = (ccol < 640) && (crow < 480);
        slot   = !vga_rdn;
        elig   = rstn && cpu_req && vga_rdn && !m_ack_now;
        if (!model_on) begin
            if (!rstn) begin
                model_reset();
                model_on = 1'b1;
            end
        end else begin
            if (slot) begin
                e_addr = d_addr;
                e_we   = 1'b0;
            end else if (elig) begin
                e_addr = cpu_addr;
                e_we   = cpu_we && inr;
            end else begin
                e_addr = m_last;
                e_we   = 1'b0;
            end
            chk("m_ram_we", 32'(ram_we), 32'(e_we));
            if (slot || elig || m_last_valid) chk("m_ram_addr", 32'(ram_addr), 32'(e_addr));
            if (e_we) chk("m_ram_wdata", 32'(ram_wdata), 32'(cpu_wdata));
            chk("m_cpu_ack", 32'(cpu_ack), 32'(m_ack_now && rstn));
            chk("m_cpu_rdata", 32'(cpu_rdata),
                32'((m_ack_now && m_ack_read) ? m_ack_val : m_rdata));
            chk("m_vga_data", 32'(vga_data), 32'(m_vga));
            chk("m_stall_cnt", 32'(stall_cnt), 32'(m_stall));
            if (cpu_ack === 1'b1) ack_cnt++;
            if (ram_we === 1'b1) we_cnt++;
            if (!rstn) begin
                model_reset();
            end else begin
                blocked = cpu_req && !vga_rdn && !m_ack_now;
                if (m_ack_now && m_ack_read) m_rdata = m_ack_val;
                if (m_s1_valid) m_vga = m_s1_val;
                m_s1_valid = slot;
                if (slot) m_s1_val = img[d_addr];
                m_ack_now = elig;
                if (elig) begin
                    m_ack_read = !cpu_we;
                    m_ack_val  = inr ? img[cpu_addr] : 12'h000;
                end
                if (e_we) img[cpu_addr] = cpu_wdata;
`ifdef VRAM_ARB_STALLCNT_EN
                if (blocked && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
                m_last       = e_addr;
                m_last_valid = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    int acks0, we0;
    logic [15:0] exp_stall;

    initial begin
        rstn = 1'b0; vga_rdn = 1'b1; vga_row = '0; vga_col = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        step(); step();
        @(negedge clk);
        chk("rst_ack", 32'(cpu_ack), 32'h0);
        chk("rst_rdata", 32'(cpu_rdata), 32'h0);
        chk("rst_vga", 32'(vga_data), 32'h0);
        chk("rst_stall", 32'(stall_cnt), 32'h0);
        chk("rst_we", 32'(ram_we), 32'h0);
        step(); rstn = 1'b1;

        // Write 0xABC to row 10, col 20, then fetch it through the display.
        step(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = {9'd10, 10'd20}; cpu_wdata = 12'hABC;
        @(negedge clk);
        chk("s1_we", 32'(ram_we), 32'h1);
        chk("s1_addr", 32'(ram_addr), 32'h02814);
        chk("s1_noack", 32'(cpu_ack), 32'h0);
        step();
        @(negedge clk);
        chk("s1_ack", 32'(cpu_ack), 32'h1);
        chk("s1_done_we", 32'(ram_we), 32'h0);
        step(); cpu_req = 1'b0; cpu_we = 1'b0; vga_rdn = 1'b0; vga_row = 10'd45; vga_col = 10'd163;
        @(negedge clk);
        chk("s1_disp_addr", 32'(ram_addr), 32'h02814);
        step(); vga_rdn = 1'b1;
        @(negedge clk);
        chk("s1_vga_early", 32'(vga_data), 32'h0);
        step();
        @(negedge clk);
        chk("s1_vga", 32'(vga_data), 32'hABC);

        // Request and display slot together, then read the pixel back.
        step(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h02814;
        vga_rdn = 1'b0; vga_row = 10'd100; vga_col = 10'd200;
        @(negedge clk);
        chk("s3_disp_addr", 32'(ram_addr), 32'h10439);
        chk("s3_we", 32'(ram_we), 32'h0);
        step(); vga_rdn = 1'b1;
        @(negedge clk);
        chk("s3_grant_addr", 32'(ram_addr), 32'h02814);
        step();
        @(negedge clk);
        chk("s3_ack", 32'(cpu_ack), 32'h1);
        chk("s3_rdata", 32'(cpu_rdata), 32'hABC);
        step(); cpu_req = 1'b0;

        // Out-of-range read: col 700 must ack with zero data.
        step(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = {9'd5, 10'd700};
        @(negedge clk);
        chk("s4_we", 32'(ram_we), 32'h0);
        chk("s4_noack", 32'(cpu_ack), 32'h0);
        step();
        @(negedge clk);
        chk("s4_ack", 32'(cpu_ack), 32'h1);
        chk("s4_rdata", 32'(cpu_rdata), 32'h0);
        step(); cpu_req = 1'b0; rstn = 1'b0;
        step(); rstn = 1'b1;

        // 640 display slots while the CPU waits.
        step(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = {9'd1, 10'd2}; cpu_wdata = 12'h123;
        vga_rdn = 1'b0; vga_row = 10'd40; vga_col = 10'd143;
        for (int i = 1; i < 640; i++) begin
            step(); vga_col = 10'(143 + i);
        end
        step(); vga_rdn = 1'b1;
`ifdef VRAM_ARB_STALLCNT_EN
        exp_stall = 16'd640;
`else
        exp_stall = 16'd0;
`endif
        @(negedge clk);
        chk("s2_we", 32'(ram_we), 32'h1);
        chk("s2_addr", 32'(ram_addr), 32'h00402);
        chk("s2_stall", 32'(stall_cnt), 32'(exp_stall));
        step();
        @(negedge clk);
        chk("s2_ack", 32'(cpu_ack), 32'h1);
        step(); cpu_req = 1'b0;

        // Reset while the request waits: no write, no ack ever.
        acks0 = ack_cnt;
        step(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = {9'd2, 10'd2}; cpu_wdata = 12'h555;
        vga_rdn = 1'b0; vga_row = 10'd50; vga_col = 10'd300;
        step();
        step(); rstn = 1'b0; vga_rdn = 1'b1;
        @(negedge clk);
        chk("s5_rst_we", 32'(ram_we), 32'h0);
        step(); rstn = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        chk("s5_ack", 32'(cpu_ack), 32'h0);
        chk("s5_rdata", 32'(cpu_rdata), 32'h0);
        chk("s5_vga", 32'(vga_data), 32'h0);
        chk("s5_stall", 32'(stall_cnt), 32'h0);

        // Request dropped while waiting.
        we0 = we_cnt;
        step(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = {9'd7, 10'd7}; cpu_wdata = 12'h777;
        vga_rdn = 1'b0;
        step();
        step(); cpu_req = 1'b0; vga_rdn = 1'b1;
        @(negedge clk);
        chk("s6_we", 32'(ram_we), 32'h0);
        step();
        @(negedge clk);
        chk("s6_ack", 32'(cpu_ack), 32'h0);
        repeat (3) step();
        chk("s6_writes", 32'(we_cnt - we0), 32'h0);
        chk("s5_s6_acks", 32'(ack_cnt - acks0), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter STALL_W, default 16: width of the CPU stall counter.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 vga_rdn  in  1  display read slot, active-low; low = pixel fetch this cycle.
REQ-005 vga_row  in  10  raw vertical count from the display timing module.
REQ-006 vga_col  in  10  raw horizontal count from the display timing module.
REQ-007 vga_data  out  12  pixel returned to the display (bbbb_gggg_rrrr).
REQ-008 cpu_req  in  1  CPU access request; held with addr/we/wdata stable until cpu_ack.
REQ-009 cpu_we  in  1  1 = write, 0 = read.
REQ-010 cpu_addr  in  19  {row[8:0], col[9:0]}.
REQ-011 cpu_wdata  in  12  write pixel.
REQ-012 cpu_ack  out  1  one-cycle completion pulse.
REQ-013 cpu_rdata  out  12  read pixel; valid in the cpu_ack cycle, held until the next read completes.
REQ-014 ram_addr  out  19  pixel RAM address.
REQ-015 ram_we  out  1  pixel RAM write enable.
REQ-016 ram_wdata  out  12  pixel RAM write data.
REQ-017 ram_rdata  in  12  pixel RAM read data, one-cycle synchronous latency.
REQ-018 stall_cnt  out  STALL_W  count of CPU cycles blocked by display slots.

Function
REQ-019 Display address SHALL be {(vga_row-35)[8:0], (vga_col-143)[9:0]}.
REQ-020 When vga_rdn=0, ram_addr SHALL be the display address and ram_we SHALL be 0, regardless of CPU state (display has absolute priority, simultaneous events included).
REQ-021 vga_data SHALL load ram_rdata in the cycle after a display slot and hold otherwise (2-cycle latency from vga_rdn low to vga_data).
REQ-022 FSM states SHALL be IDLE, WAIT, DONE.
REQ-023 The grant cycle SHALL be any cycle in IDLE or WAIT with cpu_req=1 and vga_rdn=1. In that cycle the arbiter SHALL drive ram_addr=cpu_addr, ram_wdata=cpu_wdata, and ram_we=cpu_we, and SHALL move to DONE.
REQ-024 In IDLE or WAIT with cpu_req=1 and vga_rdn=0, the FSM SHALL enter or stay in WAIT.
REQ-025 In WAIT with cpu_req=0, the FSM SHALL return to IDLE with no RAM access and no ack.
REQ-026 In DONE, cpu_ack SHALL be 1 and cpu_rdata SHALL load ram_rdata if the access was a read. The FSM SHALL move to IDLE unconditionally, ignoring cpu_req that cycle; maximum CPU throughput is one access per 2 cycles.
REQ-027 A CPU address with col>=640 or row>=480 SHALL be acked with ram_we=0; a read of it SHALL return 0x000.
REQ-028 When no grant and no display slot occur, ram_we SHALL be 0 and ram_addr SHALL hold its previous value.

Reset
REQ-029 On rstn=0 at a clock edge, the block SHALL reset to: FSM IDLE, cpu_ack 0, cpu_rdata 0x000, vga_data 0x000, stall_cnt 0, ram_we 0.
REQ-030 Reset during WAIT or DONE SHALL abort the access with no ack; the CPU re-issues.

Configuration
REQ-031 With VRAM_ARB_STALLCNT_EN defined, stall_cnt SHALL increment each cycle the FSM is in or enters WAIT, and SHALL saturate at all-ones.
REQ-032 Without VRAM_ARB_STALLCNT_EN, stall_cnt SHALL be constant 0 and the counter logic SHALL be absent.

Structure
REQ-033 Shared package vram_pkg SHALL hold: VGA_H_OFS=143, VGA_V_OFS=35, H_ACTIVE=640, V_ACTIVE=480, PIXEL_W=12, ADDR_W=19, and the FSM state enum.
REQ-034 A sub-module vram_addr_map SHALL perform offset subtraction and range checking, instantiated for the display path and the CPU path.

Verification
REQ-035 Scenario: CPU write addr {row 9'd10, col 10'd20} with data 0xABC while vga_rdn=1 -> ram_we=1 in the grant cycle and cpu_ack the next cycle. A later display slot at vga_row=45, vga_col=163 -> vga_data=0xABC two cycles later.
REQ-036 Scenario: cpu_req held through 640 consecutive vga_rdn=0 cycles -> no ram_we, grant on the first vga_rdn=1 cycle, stall_cnt=640 (macro defined).
REQ-037 Scenario: cpu_req and vga_rdn both asserted in the same cycle -> ram_addr = display address, CPU in WAIT.
REQ-038 Scenario: CPU read of col=700 -> ram_we=0, cpu_ack after 2 cycles, cpu_rdata=0x000.
REQ-039 Scenario: rstn=0 while FSM in WAIT -> next cycle all outputs at reset values and no cpu_ack is ever issued.
REQ-040 Scenario: request dropped in WAIT -> FSM in IDLE, zero RAM writes, no ack.
